width_pack_arbiter: RTL and testbench

Shares one 8-to-16 byte packer between N_SRC byte-stream requesters. Round-robin arbitration grants one source at a time. The grant is held until that source's two bytes have been packed into a 16-bit word, so bytes from different sources never mix. A per-word timeout flushes a half-filled word with zero padding, so a stalled source cannot hold the packer indefinitely. The block sits between the byte-wide sources and the 16-bit consumer, and drives both the input handshakes and the output handshake.

---
 rtl/width_pack_arbiter_if.sv | 24 ++
 rtl/width_pack_arbiter.sv | 130 +++++++++++++
 tb/tb_width_pack_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/width_pack_arbiter_if.sv
// Handshake bundle between the byte-wide requesters, the packer and the 16-bit consumer.
// master = requester/consumer side, slave = the packer.
interface width_pack_arbiter_if #(
    parameter int N_SRC = 4,
    parameter int SRC_W = $clog2(N_SRC)
);
    logic [N_SRC-1:0]   req_valid;
    logic [8*N_SRC-1:0] req_data;
    logic [N_SRC-1:0]   req_ready;
    logic               out_valid;
    logic [15:0]        out_data;
    logic [SRC_W-1:0]   out_src;
    logic               out_pad;
    logic               out_ready;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src, out_pad
    );
    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src, out_pad
    );
endinterface

// File: rtl/width_pack_arbiter.sv
// Round-robin shared 8-to-16 byte packer; grant is held for a whole word, and a
// stalled second byte is replaced by zero padding after TIMEOUT cycles.
module width_pack_arbiter #(
    parameter int N_SRC   = 4,
    parameter int SRC_W   = $clog2(N_SRC),
    parameter int TIMEOUT = 16
) (
    input logic                clk,
    input logic                rst,
    width_pack_arbiter_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, HI, LO, OUT} state_t;

    state_t           state, state_nxt;
    logic [SRC_W-1:0] grant, grant_nxt;
    logic [SRC_W-1:0] last_grant, last_grant_nxt;
    logic [7:0]       hi_byte, hi_byte_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic             ov, ov_nxt;
    logic [15:0]      od, od_nxt;
    logic [SRC_W-1:0] os, os_nxt;
    logic             op, op_nxt;

    logic [7:0]       bytes [N_SRC];
    logic [7:0]       cur_byte;
    logic             cur_valid;
    logic [SRC_W-1:0] pick, idx;
    logic             found;

    genvar g;
    generate
        for (g = 0; g < N_SRC; g++) begin : g_lane
            assign bytes[g]         = bus.req_data[8*g +: 8];
            assign bus.req_ready[g] = (state == HI || state == LO) && (grant == SRC_W'(g));
        end
    endgenerate

    assign cur_byte      = bytes[grant];
    assign cur_valid     = bus.req_valid[grant];
    assign bus.out_valid = ov;
    assign bus.out_data  = od;
    assign bus.out_src   = os;
    assign bus.out_pad   = op;

    // Walk downward so the nearest source after last_grant wins.
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        idx   = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            idx = SRC_W'((int'(last_grant) + k) % N_SRC);
            if (bus.req_valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        hi_byte_nxt    = hi_byte;
        timer_nxt      = timer;
        ov_nxt         = ov;
        od_nxt         = od;
        os_nxt         = os;
        op_nxt         = op;
        case (state)
            IDLE: if (found) begin
                grant_nxt = pick;
                state_nxt = HI;
            end
            HI: if (cur_valid) begin
                hi_byte_nxt = cur_byte;
                timer_nxt   = '0;
                state_nxt   = LO;
            end else begin
                state_nxt = IDLE;
            end
            LO: if (cur_valid) begin
                od_nxt    = {hi_byte, cur_byte};
                op_nxt    = 1'b0;
                os_nxt    = grant;
                ov_nxt    = 1'b1;
                state_nxt = OUT;
            end else if (timer == TW'(TIMEOUT - 1)) begin
                od_nxt    = {hi_byte, 8'h00};
                op_nxt    = 1'b1;
                os_nxt    = grant;
                ov_nxt    = 1'b1;
                state_nxt = OUT;
            end else begin
                timer_nxt = timer + TW'(1);
            end
            OUT: if (bus.out_ready) begin
                ov_nxt         = 1'b0;
                last_grant_nxt = grant;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= SRC_W'(N_SRC - 1);
            hi_byte    <= '0;
            timer      <= '0;
            ov         <= 1'b0;
            od         <= '0;
            os         <= '0;
            op         <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            hi_byte    <= hi_byte_nxt;
            timer      <= timer_nxt;
            ov         <= ov_nxt;
            od         <= od_nxt;
            os         <= os_nxt;
            op         <= op_nxt;
        end
    end
endmodule

// File: tb/tb_width_pack_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level scoreboard
// that pairs accepted bytes per source into expected words.
module tb_width_pack_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam int SW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    width_pack_arbiter_if #(.N_SRC(N)) bus();
    width_pack_arbiter #(.N_SRC(N), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: bytes seen crossing the handshake form the expected word.
    int          nb = 0;
    int          wsrc = 0, e_first = 0, e_second = 0;
    logic [7:0]  b0 = 0, b1 = 0;
    logic        prev_ov = 1'b0;
    logic [15:0] w_data = 0;
    logic [SW-1:0] w_src = 0;
    logic        w_pad = 0;

    always @(negedge clk) begin
        logic [N-1:0] acc;
        int s;
        if (rst) begin
            nb      = 0;
            prev_ov = 1'b0;
        end else begin
            acc = bus.req_valid & bus.req_ready;
            if (acc != '0) begin
                chk("acc_onehot", $countones(acc), 1);
                chk("acc_in_out", bus.out_valid, 0);
                s = 0;
                for (int i = 0; i < N; i++) if (acc[i]) s = i;
                if (nb == 0) begin
                    wsrc = s; b0 = bus.req_data[8*s +: 8]; e_first = cyc + 1; nb = 1;
                end else begin
                    chk("acc_src", s, wsrc);
                    chk("acc_extra", nb, 1);
                    b1 = bus.req_data[8*s +: 8]; e_second = cyc + 1; nb = 2;
                end
            end
            if (bus.out_valid) begin
                chk("ready_in_out", bus.req_ready, 0);
                if (!prev_ov) begin
                    chk("word_src", bus.out_src, wsrc);
                    if (bus.out_pad) begin
                        chk("pad_nb", nb, 1);
                        chk("pad_data", bus.out_data, {b0, 8'h00});
                        chk("pad_time", cyc - e_first, TO);
                    end else begin
                        chk("word_nb", nb, 2);
                        chk("word_data", bus.out_data, {b0, b1});
                        chk("word_time", cyc - e_second, 0);
                    end
                    w_data = bus.out_data; w_src = bus.out_src; w_pad = bus.out_pad;
                end else begin
                    chk("hold_data", bus.out_data, w_data);
                    chk("hold_src", bus.out_src, w_src);
                    chk("hold_pad", bus.out_pad, w_pad);
                end
                if (bus.out_ready) nb = 0;
            end
            prev_ov = bus.out_valid;
        end
    end

    // Directed-stimulus helpers: each source presents pat_hi then pat_lo.
    logic [7:0] pat_hi [N];
    logic [7:0] pat_lo [N];
    int         bcnt   [N];
    int         got_src[$];
    logic [15:0] got_data[$];
    logic       got_pad[$];

    task automatic drive();
        for (int i = 0; i < N; i++)
            bus.req_data[8*i +: 8] = (bcnt[i] % 2 == 1) ? pat_lo[i] : pat_hi[i];
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic adv();
        logic [N-1:0] a;
        a = bus.req_valid & bus.req_ready;
        step();
        for (int i = 0; i < N; i++) if (a[i]) bcnt[i]++;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) bcnt[i] = 0;
        drive();
        step();
        rst = 1'b0;
    endtask

    task automatic collect(input int nw, input int budget);
        got_src.delete(); got_data.delete(); got_pad.delete();
        for (int k = 0; k < budget && got_src.size() < nw; k++) begin
            if (bus.out_valid && bus.out_ready) begin
                got_src.push_back(int'(bus.out_src));
                got_data.push_back(bus.out_data);
                got_pad.push_back(bus.out_pad);
            end
            adv();
        end
        chk("collect_cnt", got_src.size(), nw);
    endtask

    initial begin
        int p;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            pat_hi[i] = 8'h00; pat_lo[i] = 8'h00; bcnt[i] = 0;
        end
        step(); step();
        chk("rst_ov",    bus.out_valid, 0);
        chk("rst_data",  bus.out_data, 16'h0000);
        chk("rst_src",   bus.out_src, 0);
        chk("rst_pad",   bus.out_pad, 0);
        chk("rst_ready", bus.req_ready, 0);
        rst = 1'b0;
        step();

        // single source, latency
        pat_hi[2] = 8'hAB; pat_lo[2] = 8'hCD; drive();
        bus.req_valid = 4'b0100;
        adv(); chk("ss_ready_hi", bus.req_ready, 4'b0100);
        adv(); chk("ss_ready_lo", bus.req_ready, 4'b0100); chk("ss_ov_early", bus.out_valid, 0);
        adv(); bus.req_valid = '0;
        chk("ss_ov", bus.out_valid, 1);
        chk("ss_data", bus.out_data, 16'hABCD);
        chk("ss_src", bus.out_src, 2);
        chk("ss_pad", bus.out_pad, 0);
        adv(); adv();

        // round robin from reset
        do_reset();
        for (int i = 0; i < N; i++) begin
            pat_hi[i] = 8'h10 + 8'(i); pat_lo[i] = 8'h20 + 8'(i);
        end
        drive();
        bus.req_valid = 4'hF;
        collect(5, 60);
        bus.req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            if (k < got_src.size()) begin
                chk("rr_src", got_src[k], k % N);
                chk("rr_data", got_data[k], {8'h10 + 8'(k % N), 8'h20 + 8'(k % N)});
                chk("rr_pad", got_pad[k], 0);
            end
        end
        adv(); adv();

        // timeout flush, then second byte on the last allowed cycle
        pat_hi[1] = 8'h5A; pat_lo[1] = 8'h77; bcnt[1] = 0; drive();
        bus.req_valid = 4'b0010;
        adv(); adv(); bus.req_valid = '0;
        repeat (15) adv();
        chk("to_early", bus.out_valid, 0);
        adv();
        chk("to_ov", bus.out_valid, 1);
        chk("to_data", bus.out_data, 16'h5A00);
        chk("to_pad", bus.out_pad, 1);
        chk("to_src", bus.out_src, 1);
        adv(); adv();
        bcnt[1] = 0; drive();
        bus.req_valid = 4'b0010;
        adv(); adv(); bus.req_valid = '0;
        repeat (15) adv();
        bus.req_valid = 4'b0010;
        adv(); bus.req_valid = '0;
        chk("tl_ov", bus.out_valid, 1);
        chk("tl_data", bus.out_data, 16'h5A77);
        chk("tl_pad", bus.out_pad, 0);
        adv(); adv();

        // backpressure
        do_reset();
        pat_hi[0] = 8'h01; pat_lo[0] = 8'h02; pat_hi[3] = 8'h31; pat_lo[3] = 8'h32; drive();
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 20 && !bus.out_valid; k++) adv();
        chk("bp_ov", bus.out_valid, 1);
        chk("bp_data", bus.out_data, 16'h0102);
        bus.req_valid = 4'b1001;
        repeat (10) begin
            adv();
            chk("bp_hold_ov", bus.out_valid, 1);
            chk("bp_hold_data", bus.out_data, 16'h0102);
            chk("bp_ready0", bus.req_ready, 0);
        end
        bus.out_ready = 1'b1;
        adv(); adv();
        chk("bp_next", bus.req_ready, 4'b1000);
        bus.req_valid = '0;
        adv(); adv();

        // grant dropout keeps priority
        do_reset();
        pat_hi[0] = 8'hC1; pat_lo[0] = 8'hC2; pat_hi[1] = 8'hD1; pat_lo[1] = 8'hD2; drive();
        bus.req_valid = 4'b0001;
        adv(); bus.req_valid = '0;
        chk("dr_hi", bus.req_ready, 4'b0001);
        adv();
        chk("dr_idle", bus.req_ready, 0);
        chk("dr_ov", bus.out_valid, 0);
        bus.req_valid = 4'b0011;
        adv();
        chk("dr_prio", bus.req_ready, 4'b0001);
        collect(1, 20);
        bus.req_valid = '0;
        if (got_src.size() > 0) begin
            chk("dr_src", got_src[0], 0);
            chk("dr_data", got_data[0], 16'hC1C2);
        end
        adv(); adv();

        // reset while in LO
        pat_hi[2] = 8'hEE; pat_lo[2] = 8'h99; bcnt[2] = 0; drive();
        bus.req_valid = 4'b0100;
        adv(); adv(); bus.req_valid = '0;
        adv();
        rst = 1'b1;
        #1;
        chk("rl_ov", bus.out_valid, 0);
        chk("rl_data", bus.out_data, 16'h0000);
        chk("rl_src", bus.out_src, 0);
        chk("rl_ready", bus.req_ready, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) bcnt[i] = 0;
        pat_hi[1] = 8'h33; pat_lo[1] = 8'h44; drive();
        bus.req_valid = 4'b0010;
        collect(1, 20);
        bus.req_valid = '0;
        if (got_src.size() > 0) begin
            chk("rl_new_data", got_data[0], 16'h3344);
            chk("rl_new_src", got_src[0], 1);
            chk("rl_new_pad", got_pad[0], 0);
        end
        adv(); adv();

        // randomized traffic, scoreboard only
        for (int seg = 0; seg < 6; seg++) begin
            case (seg)
                0: p = 90;
                1: p = 50;
                2: p = 10;
                3: p = 70;
                4: p = 3;
                default: p = 95;
            endcase
            repeat (500) begin
                step();
                for (int i = 0; i < N; i++) begin
                    bus.req_valid[i]       = ($urandom_range(0, 99) < p);
                    bus.req_data[8*i +: 8] = 8'($urandom());
                end
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
